// File: rtl/daric_pkg.sv
// Shared types and constants for the elastic pipeline register.
package daric_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int DATA_W = 32;

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a one-entry skid buffer. Every handshake-side
// output comes straight from a flop, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg
  import daric_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Handshake: a word moves on a rising edge only when valid and ready are both
  // high on that side; valid never depends on ready, and ready never depends on
  // the same cycle's out_ready.

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flags are precomputed from the next state so they leave the block registered.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d == BUSY) || (state_d == FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed skid/stall cases plus a long
// random valid/ready run against an in-order expected queue.
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic [W-1:0] exp_q[$];
  int           total;
  int           bad;
  logic         stall_prev;
  logic [W-1:0] data_prev;
  logic [W-1:0] next_word;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Observe the handshake at the falling edge, then let one rising edge pass.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    chk("occupancy", {30'd0, occupancy}, exp_q.size());
    if (stall_prev && out_valid) chk("stable", out_data, data_prev);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_data, 'x);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e);
      end
    end
    if (in_valid && in_ready) exp_q.push_back(in_data);
    stall_prev = out_valid && !out_ready;
    data_prev  = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", {31'd0, out_valid}, 0);
  endtask

  task automatic send_one(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    stall_prev = 1'b0;
    data_prev = '0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    chk("rst_occ", {30'd0, occupancy}, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      chk("stream_ready", {31'd0, in_ready}, 1);
      tick();
      if (i == 1) chk("stream_latency", {31'd0, out_valid}, 1);
    end
    drain();

    // stall / skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 32'hA; tick();
    chk("skid_ready_busy", {31'd0, in_ready}, 1);
    in_data = 32'hB; tick();
    in_data = 32'hC; tick();
    chk("skid_occ", {30'd0, occupancy}, 2);
    chk("skid_ready", {31'd0, in_ready}, 0);
    chk("skid_head", out_data, 32'hA);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10 && in_valid; i++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    chk("skid_c_taken", {31'd0, in_valid}, 0);
    drain();

    // simultaneous transfer in BUSY
    out_ready = 1'b0;
    send_one(32'h55);
    tick();
    chk("sim_head", out_data, 32'h55);
    in_valid  = 1'b1;
    in_data   = 32'h66;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sim_data", out_data, 32'h66);
    chk("sim_occ", {30'd0, occupancy}, 1);
    drain();

    // idle gaps while BUSY and stalled
    out_ready = 1'b0;
    send_one(32'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_data", out_data, 32'h77);
      chk("idle_occ", {30'd0, occupancy}, 1);
    end
    drain();

    // random valid/ready with incrementing data
    next_word = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = next_word;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) next_word = next_word + 1;
      tick();
    end
    in_valid = 1'b0;
    drain();

    // asynchronous reset while FULL
    out_ready = 1'b0;
    send_one(32'hD1);
    send_one(32'hD2);
    chk("pre_rst_occ", {30'd0, occupancy}, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 0);
    chk("arst_ready", {31'd0, in_ready}, 1);
    chk("arst_data", out_data, 0);
    chk("arst_occ", {30'd0, occupancy}, 0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_one(32'hE1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
